// File: rtl/rh_dma_pkg.sv
// Shared types and constants for the RH DMA word sequencer.
// Widths, FSM state encoding and the bus-timeout limit.
package rh_dma_pkg;

  localparam int AW = 18;
  localparam int DW = 36;
  localparam int WCW = 16;
  localparam int TO_LIMIT = 256;
  localparam int TO_W = $clog2(TO_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_REQ,
    S_PUSH,
    S_STEP,
    S_DONE
  } state_t;

endpackage

// File: rtl/rh_dma_timeout.sv
// Non-existent-memory watchdog: counts unacknowledged bus-request cycles.
// Only instantiated when RH_DMA_SEQ_TIMEOUT_EN is defined.
module rh_dma_timeout
  import rh_dma_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ack,
  output logic expire
);

  logic [TO_W-1:0] cnt;
  logic            stall;

  assign stall = active && !ack;

  // Leaving the request state zeroes the count, so every entry starts fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (stall) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  assign expire = stall && (cnt == TO_W'(TO_LIMIT - 1));

endmodule

// File: rtl/rh_dma_seq.sv
// RH DMA word sequencer: moves one 36-bit word per step between device and bus.
// Define RH_DMA_SEQ_TIMEOUT_EN to enable the non-existent-memory bus timeout.
module rh_dma_seq
  import rh_dma_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          go,
  input  logic          rev,
  input  logic          to_mem,
  input  logic [WCW-1:0] wc_in,
  input  logic [AW-1:0] ba_in,
  input  logic [DW-1:0] dev_in_data,
  input  logic          dev_in_valid,
  output logic          dev_in_ready,
  output logic [DW-1:0] dev_out_data,
  output logic          dev_out_valid,
  input  logic          dev_out_ready,
  output logic          bus_req,
  output logic          bus_write,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata,
  output logic          inc_ba,
  output logic          dec_ba,
  output logic          wc_inc,
  output logic          busy,
  output logic          done,
  output logic          nxm
);

  state_t          state;
  state_t          state_n;
  logic [WCW-1:0]  wc_q;
  logic [WCW-1:0]  wc_nxt;
  logic            mem_q;
  logic            rev_q;
  logic            start;
  logic            take_in;
  logic            take_rd;
  logic            step;
  logic            expire;

`ifdef RH_DMA_SEQ_TIMEOUT_EN
  rh_dma_timeout u_timeout (
    .clk    (clk),
    .rst    (rst),
    .active (state == S_REQ),
    .ack    (bus_ack),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

  assign wc_nxt = wc_q + 1'b1;

  always_comb begin
    state_n       = state;
    busy          = (state != S_IDLE);
    bus_req       = 1'b0;
    dev_in_ready  = 1'b0;
    dev_out_valid = 1'b0;
    inc_ba        = 1'b0;
    dec_ba        = 1'b0;
    wc_inc        = 1'b0;
    done          = 1'b0;
    start         = 1'b0;
    take_in       = 1'b0;
    take_rd       = 1'b0;
    step          = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (go && !clr) begin
          start   = 1'b1;
          state_n = to_mem ? S_WAIT_DATA : S_REQ;
        end
      end
      S_WAIT_DATA: begin
        dev_in_ready = !clr;
        if (dev_in_valid) begin
          take_in = !clr;
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        bus_req = 1'b1;
        if (bus_ack) begin
          take_rd = !mem_q && !clr;
          state_n = mem_q ? S_STEP : S_PUSH;
        end else if (expire) begin
          state_n = S_DONE;
        end
      end
      S_PUSH: begin
        dev_out_valid = 1'b1;
        if (dev_out_ready) state_n = S_STEP;
      end
      S_STEP: begin
        step   = !clr;
        inc_ba = !rev_q && !clr;
        dec_ba = rev_q && !clr;
        wc_inc = !clr;
        if (wc_nxt == '0) begin
          state_n = S_DONE;
        end else begin
          state_n = mem_q ? S_WAIT_DATA : S_REQ;
        end
      end
      S_DONE: begin
        done    = !clr;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // Abort wins over every handshake completing in the same cycle.
    if (clr) state_n = S_IDLE;
  end

  assign bus_write = bus_req && mem_q;
  assign bus_addr  = bus_req ? ba_in : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      wc_q         <= '0;
      mem_q        <= 1'b0;
      rev_q        <= 1'b0;
      bus_wdata    <= '0;
      dev_out_data <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        wc_q  <= wc_in;
        mem_q <= to_mem;
        rev_q <= rev;
      end
      if (take_in) bus_wdata <= dev_in_data;
      if (take_rd) dev_out_data <= bus_rdata;
      if (step) wc_q <= wc_nxt;
    end
  end

`ifdef RH_DMA_SEQ_TIMEOUT_EN
  logic nxm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      nxm_q <= 1'b0;
    end else if (start) begin
      nxm_q <= 1'b0;
    end else if (state == S_REQ && expire && !clr) begin
      nxm_q <= 1'b1;
    end
  end

  assign nxm = nxm_q;
`else
  assign nxm = 1'b0;
`endif

endmodule

// File: tb/tb_rh_dma_seq.sv
// Directed bench for rh_dma_seq with a transaction-level scoreboard.
// Build with RH_DMA_SEQ_TIMEOUT_EN to exercise the bus timeout.
module tb_rh_dma_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        go;
  logic        rev;
  logic        to_mem;
  logic [15:0] wc_in;
  logic [17:0] ba_in;
  logic [35:0] dev_in_data;
  logic        dev_in_valid;
  logic        dev_in_ready;
  logic [35:0] dev_out_data;
  logic        dev_out_valid;
  logic        dev_out_ready;
  logic        bus_req;
  logic        bus_write;
  logic [17:0] bus_addr;
  logic [35:0] bus_wdata;
  logic        bus_ack;
  logic [35:0] bus_rdata;
  logic        inc_ba;
  logic        dec_ba;
  logic        wc_inc;
  logic        busy;
  logic        done;
  logic        nxm;

  rh_dma_seq dut (
    .clk           (clk),
    .rst           (rst),
    .clr           (clr),
    .go            (go),
    .rev           (rev),
    .to_mem        (to_mem),
    .wc_in         (wc_in),
    .ba_in         (ba_in),
    .dev_in_data   (dev_in_data),
    .dev_in_valid  (dev_in_valid),
    .dev_in_ready  (dev_in_ready),
    .dev_out_data  (dev_out_data),
    .dev_out_valid (dev_out_valid),
    .dev_out_ready (dev_out_ready),
    .bus_req       (bus_req),
    .bus_write     (bus_write),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_ack       (bus_ack),
    .bus_rdata     (bus_rdata),
    .inc_ba        (inc_ba),
    .dec_ba        (dec_ba),
    .wc_inc        (wc_inc),
    .busy          (busy),
    .done          (done),
    .nxm           (nxm)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int   ack_dly;
  int   age;
  logic pinc;
  logic pdec;

  logic        exp_mem;
  logic        exp_rev;
  logic [35:0] exp_wdata;
  int          exp_n;
  int n_bus, n_rd, n_wr, n_inc, n_dec, n_wc, n_done, n_acc;
  int run_steps, run_bus;
  logic [35:0] rq[$];
  logic [17:0] alog[$];
  logic [35:0] hold_data;
  logic        hold_v;

  function automatic logic [35:0] memf(input logic [17:0] a);
    return {a, ~a} ^ 36'h0F0F0F0F0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the transfer model.
  task automatic compare_cycle();
    if (!rst) begin
      if (bus_req) begin
        chk("bus_write", 64'(bus_write), 64'(exp_mem));
        chk("bus_addr", 64'(bus_addr), 64'(ba_in));
        if (exp_mem) chk("bus_wdata", 64'(bus_wdata), 64'(exp_wdata));
        if (bus_ack && !clr) begin
          n_bus++;
          run_bus++;
          alog.push_back(bus_addr);
          if (bus_write) n_wr++;
          else begin
            n_rd++;
            rq.push_back(memf(bus_addr));
          end
        end
      end
      if (bus_req || dev_in_ready || dev_out_valid || wc_inc || done)
        chk("busy_active", 64'(busy), 64'd1);
      if (dev_in_ready && dev_in_valid) n_acc++;
      if (dev_out_valid) begin
        if (rq.size() != 1) chk("rd_pending", 64'(rq.size()), 64'd1);
        else chk("dev_out_data", 64'(dev_out_data), 64'(rq[0]));
        if (hold_v) chk("dout_stable", 64'(dev_out_data), 64'(hold_data));
        hold_v = !dev_out_ready;
        hold_data = dev_out_data;
        if (dev_out_ready && rq.size() > 0) void'(rq.pop_front());
      end else begin
        hold_v = 1'b0;
      end
      chk("step_excl", 64'(inc_ba & dec_ba), 64'd0);
      chk("wc_inc_pair", 64'(wc_inc), 64'(inc_ba | dec_ba));
      if (wc_inc) begin
        n_wc++;
        run_steps++;
        chk("step_dir", 64'(dec_ba), 64'(exp_rev));
      end
      if (inc_ba) n_inc++;
      if (dec_ba) n_dec++;
      if (done) begin
        n_done++;
        if (nxm) chk("nxm_no_step", 64'(run_steps), 64'(run_bus));
        else chk("done_count", 64'(run_steps), 64'(exp_n));
      end
    end
  endtask

  // One clock: compare, then act as bus-address register and bus slave.
  task automatic tick();
    @(negedge clk);
    compare_cycle();
    pinc = inc_ba;
    pdec = dec_ba;
    @(posedge clk);
    #1;
    if (!rst) begin
      if (pinc) ba_in = ba_in + 18'd1;
      if (pdec) ba_in = ba_in - 18'd1;
    end
    age = bus_req ? age + 1 : 0;
    bus_ack = bus_req && ack_dly >= 0 && age == ack_dly + 1;
    bus_rdata = memf(ba_in);
  endtask

  task automatic start(input logic m, input logic r,
                       input logic [15:0] wc, input logic [17:0] ba);
    exp_mem = m;
    exp_rev = r;
    exp_n = (wc == 16'd0) ? 65536 : 65536 - int'(wc);
    run_steps = 0;
    run_bus = 0;
    to_mem = m;
    rev = r;
    wc_in = wc;
    ba_in = ba;
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic run_to_done(input string nm, input int budget);
    int d0;
    int c;
    d0 = n_done;
    c = 0;
    while (c < budget && n_done == d0) begin
      tick();
      c++;
    end
    chk(nm, 64'(n_done - d0), 64'd1);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_strobes"},
        64'({bus_req, bus_write, dev_in_ready, dev_out_valid, inc_ba,
             dec_ba, wc_inc, done, busy, nxm}), 64'd0);
    chk({nm, "_wdata"}, 64'(bus_wdata), 64'd0);
    chk({nm, "_dout"}, 64'(dev_out_data), 64'd0);
    chk({nm, "_addr"}, 64'(bus_addr), 64'd0);
  endtask

  initial begin
    int b_rd, b_wr, b_inc, b_dec, b_wc, b_acc, b_bus, b_done, a0, nreq;
    logic [35:0] d;
    rst = 1'b1; clr = 1'b0; go = 1'b0; rev = 1'b0; to_mem = 1'b0;
    wc_in = '0; ba_in = 18'o7; dev_in_data = '0; dev_in_valid = 1'b0;
    dev_out_ready = 1'b1; bus_ack = 1'b0; bus_rdata = '0;
    ack_dly = 0; age = 0; pinc = 1'b0; pdec = 1'b0;
    exp_mem = 1'b0; exp_rev = 1'b0; exp_wdata = '0; exp_n = 0;
    n_bus = 0; n_rd = 0; n_wr = 0; n_inc = 0; n_dec = 0; n_wc = 0;
    n_done = 0; n_acc = 0; run_steps = 0; run_bus = 0;
    hold_data = '0; hold_v = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk_reset_vals("reset");

    // Three reads upward, ack two cycles after each request.
    ack_dly = 2;
    b_rd = n_rd; b_wr = n_wr; b_inc = n_inc; b_dec = n_dec; b_wc = n_wc;
    b_bus = n_bus; a0 = alog.size();
    start(1'b0, 1'b0, 16'hFFFD, 18'o1000);
    run_to_done("rd3_done", 100);
    chk("rd3_bus", 64'(n_bus - b_bus), 64'd3);
    chk("rd3_reads", 64'(n_rd - b_rd), 64'd3);
    chk("rd3_writes", 64'(n_wr - b_wr), 64'd0);
    chk("rd3_inc", 64'(n_inc - b_inc), 64'd3);
    chk("rd3_dec", 64'(n_dec - b_dec), 64'd0);
    chk("rd3_wc", 64'(n_wc - b_wc), 64'd3);
    chk("rd3_ba", 64'(ba_in), 64'(18'o1003));
    chk("rd3_addr0", 64'(alog[a0]), 64'(18'o1000));
    chk("rd3_addr2", 64'(alog[a0+2]), 64'(18'o1002));
    tick();
    chk("rd3_idle", 64'(busy), 64'd0);

    // Single reverse write with device data held valid.
    ack_dly = 0;
    dev_in_valid = 1'b1;
    dev_in_data = 36'o123456701234;
    exp_wdata = 36'o123456701234;
    b_wr = n_wr; b_rd = n_rd; b_inc = n_inc; b_dec = n_dec; b_acc = n_acc;
    start(1'b1, 1'b1, 16'hFFFF, 18'o2000);
    run_to_done("wr1_done", 50);
    dev_in_valid = 1'b0;
    chk("wr1_writes", 64'(n_wr - b_wr), 64'd1);
    chk("wr1_reads", 64'(n_rd - b_rd), 64'd0);
    chk("wr1_dec", 64'(n_dec - b_dec), 64'd1);
    chk("wr1_inc", 64'(n_inc - b_inc), 64'd0);
    chk("wr1_accept", 64'(n_acc - b_acc), 64'd1);
    chk("wr1_wdata", 64'(bus_wdata), 64'(36'o123456701234));
    chk("wr1_ba", 64'(ba_in), 64'(18'o1777));
    chk("wr1_addr", 64'(alog[alog.size()-1]), 64'(18'o2000));

    // Read with device back-pressure; late go and mode changes ignored.
    ack_dly = 1;
    dev_out_ready = 1'b0;
    b_wc = n_wc;
    start(1'b0, 1'b0, 16'hFFFF, 18'o300);
    for (int i = 0; i < 20 && !dev_out_valid; i++) tick();
    chk("bp_push", 64'(dev_out_valid), 64'd1);
    d = dev_out_data;
    chk("bp_data", 64'(d), 64'(memf(18'o300)));
    to_mem = 1'b1;
    rev = 1'b1;
    go = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      go = 1'b0;
      chk("bp_valid", 64'(dev_out_valid), 64'd1);
      chk("bp_hold", 64'(dev_out_data), 64'(d));
      chk("bp_nostep", 64'(wc_inc), 64'd0);
    end
    dev_out_ready = 1'b1;
    tick();
    chk("bp_step", 64'({wc_inc, inc_ba, dec_ba}), 64'(3'b110));
    run_to_done("bp_done", 20);
    chk("bp_wc", 64'(n_wc - b_wc), 64'd1);
    to_mem = 1'b0;
    rev = 1'b0;
    tick();

    // Abort in the request state coinciding with bus_ack.
    ack_dly = -1;
    start(1'b0, 1'b0, 16'hFFFE, 18'o400);
    repeat (3) tick();
    chk("clr_inreq", 64'(bus_req), 64'd1);
    b_wc = n_wc; b_done = n_done; b_rd = n_rd;
    clr = 1'b1;
    bus_ack = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_idle", 64'({busy, bus_req, dev_out_valid}), 64'd0);
    repeat (5) tick();
    chk("clr_nostep", 64'(n_wc - b_wc), 64'd0);
    chk("clr_nodone", 64'(n_done - b_done), 64'd0);
    chk("clr_noread", 64'(n_rd - b_rd), 64'd0);

    // Reset while waiting for device data.
    ack_dly = 0;
    start(1'b1, 1'b0, 16'hFFFE, 18'o500);
    repeat (3) tick();
    chk("rst_waitdata", 64'({busy, dev_in_ready}), 64'(2'b11));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hold_v = 1'b0;
    rq.delete();
    chk_reset_vals("midrst");
    tick();
    chk("midrst_stay", 64'(busy), 64'd0);

`ifdef RH_DMA_SEQ_TIMEOUT_EN
    // No ack ever: request must time out after exactly 256 cycles.
    ack_dly = -1;
    start(1'b0, 1'b0, 16'hFFFF, 18'o600);
    nreq = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (bus_req) nreq++;
      tick();
    end
    chk("to_req_cycles", 64'(nreq), 64'd256);
    chk("to_done", 64'(done), 64'd1);
    chk("to_nxm", 64'(nxm), 64'd1);
    chk("to_noreq", 64'(bus_req), 64'd0);
    tick();
    chk("to_nxm_sticky", 64'(nxm), 64'd1);
    // Ack landing in the 256th cycle still wins.
    ack_dly = 255;
    b_rd = n_rd;
    start(1'b0, 1'b0, 16'hFFFF, 18'o700);
    chk("to_go_clears", 64'(nxm), 64'd0);
    run_to_done("to_edge_done", 400);
    chk("to_edge_read", 64'(n_rd - b_rd), 64'd1);
    chk("to_edge_nxm", 64'(nxm), 64'd0);
`else
    // Without the timeout the request waits indefinitely.
    ack_dly = -1;
    b_done = n_done;
    start(1'b0, 1'b0, 16'hFFFF, 18'o600);
    nreq = 0;
    for (int i = 0; i < 300; i++) begin
      if (bus_req) nreq++;
      tick();
    end
    chk("nto_req_cycles", 64'(nreq), 64'd300);
    chk("nto_still_req", 64'(bus_req), 64'd1);
    chk("nto_nxm", 64'(nxm), 64'd0);
    chk("nto_nodone", 64'(n_done - b_done), 64'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("nto_clr_idle", 64'(busy), 64'd0);
`endif

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
